// File: rtl/calc_result_bcd.sv
// Sequential shift-and-add-3 binary to BCD converter for the calculator result.
// Ports: clk, rst, start, result, overflow in; busy, done, bcd, err out.
module calc_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      result,
  input  logic                  overflow,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  bin_q;
  logic [BW-1:0]     scr_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic [BW-1:0]     bcd_q;
  logic              err_q;
  logic              done_q;

  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] sh;

  // Each digit is corrected on its own; a digit <= 9 plus 3 fits in
  // 4 bits, so no carry ever crosses into the neighbour.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = scr_q[4*i +: 4];
    end
    sh = {adj, bin_q} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered at the edge leaving S_DONE so it coincides
  // with the cycle in which bcd/err first show the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      bcd_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            bin_q <= result;
            scr_q <= '0;
            ovf_q <= overflow;
            cnt_q <= CW'(WIDTH);
          end
        end
        S_SHIFT: begin
          {scr_q, bin_q} <= sh;
          cnt_q          <= cnt_q - CW'(1);
        end
        S_DONE: begin
          bcd_q  <= scr_q;
          err_q  <= ovf_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign err  = err_q;

endmodule

// File: tb/tb_calc_result_bcd.sv
// Scoreboard bench for calc_result_bcd.
// Expectations are queued on start and checked on each done pulse.
module tb_calc_result_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  typedef struct packed {
    logic [11:0] bcd;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  result = '0;
  logic              overflow = 1'b0;
  logic              busy;
  logic              done;
  logic [11:0]       bcd;
  logic              err;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  calc_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .result(result),
    .overflow(overflow), .busy(busy), .done(done),
    .bcd(bcd), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    b[11:8] = 4'(v / 100);
    b[7:4]  = 4'((v / 10) % 10);
    b[3:0]  = 4'(v % 10);
    return b;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done bcd=%h err=%b", bcd, err);
      end else begin
        e = exp_q.pop_front();
        if (bcd !== e.bcd || err !== e.err) begin
          errors++;
          $display("FAIL result bcd=%h err=%b want bcd=%h err=%b",
                   bcd, err, e.bcd, e.err);
        end
      end
    end
  end

  task automatic push(input int v, input logic o);
    exp_t e;
    e.bcd = to_bcd(v);
    e.err = o;
    exp_q.push_back(e);
  endtask

  task automatic start_conv(input int v, input logic o);
    @(negedge clk);
    result = 8'(v);
    overflow = o;
    start = 1'b1;
    push(v, o);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got=%b want=1", busy);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    checks++;
    if (n != WIDTH + 1) begin
      errors++;
      $display("FAIL latency_%s got=%0d want=%0d", tag, n, WIDTH + 1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, bcd, err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b bcd=%h err=%b want 0",
               busy, done, bcd, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_max;
    start_conv(255, 1'b0);
    wait_done("max");
  endtask

  task automatic test_bounds;
    start_conv(0, 1'b0);
    wait_done("zero");
    start_conv(99, 1'b0);
    wait_done("n99");
    start_conv(100, 1'b0);
    wait_done("n100");
  endtask

  task automatic test_err;
    start_conv(37, 1'b1);
    wait_done("err1");
    start_conv(37, 1'b0);
    wait_done("err0");
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    @(negedge clk);
    result = 8'd200;
    overflow = 1'b0;
    start = 1'b1;
    repeat (3) push(200, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL held_start_pulses got=%0d want=3", pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_start_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_inflight;
    int n = 0;
    int bad = 0;
    @(negedge clk);
    result = 8'd128;
    overflow = 1'b0;
    start = 1'b1;
    push(128, 1'b0);
    @(negedge clk);
    start = 1'b0;
    result = 8'd5;
    overflow = 1'b1;
    while (!done && n < 30) begin
      if (bcd !== 12'h200 || err !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad != 0 || !done) begin
      errors++;
      $display("FAIL hold_during_conv bad=%0d done=%b want 0 and 1",
               bad, done);
    end
  endtask

  task automatic test_reset_mid;
    start_conv(77, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, bcd, err} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset busy=%b done=%b bcd=%h err=%b want 0",
               busy, done, bcd, err);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    result = 8'd9;
    overflow = 1'b0;
    start = 1'b1;
    push(9, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_max;
    test_bounds;
    test_err;
    test_back_to_back;
    test_inflight;
    test_reset_mid;
    repeat (15) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
